seq_detect_prog: RTL
====================

# seq_detect_prog

Programmable serial bit-pattern detector, the parametrised successor to the fixed-pattern 1011 detector. It samples one bit per qualified clock and pulses `seq_seen` when the last `cfg_len` bits match a run-time-loaded pattern of up to `MAX_LEN` bits. Detection runs in overlapping or non-overlapping mode. A saturating match counter is optional. The block sits on the same serial input path as the fixed detector and replaces it wherever the pattern must be configurable.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits; legal range 2..32.
- `CNT_W`, 8: width of `match_cnt`.
- `DEFAULT_PATTERN`, 'b1011: pattern applied at reset, right-aligned.
- `DEFAULT_LEN`, 4: length applied at reset.
- `DEFAULT_OVERLAP`, 1: overlap mode applied at reset.
- `LEN_W`, derived as `$clog2(MAX_LEN+1)`; not overridable.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inp_bit`  in  1  serial data bit.
- `inp_valid`  in  1  `inp_bit` is sampled only when this is high.
- `cfg_load`  in  1  one-cycle strobe that loads `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `cfg_len-1` is the first bit received and bit 0 is the last.
- `cfg_len`  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches allowed.
- `seq_seen`  out  1  registered match pulse.
- `cfg_err`  out  1  registered pulse on an illegal load.
- `match_cnt`  out  CNT_W  saturating match count; present only with `SEQ_DETECT_MATCH_CNT_EN`.

## Operation
State held by the block:
- `hist[MAX_LEN-1:0]`: shift register of received bits.
- `fill`: count of valid history bits, 0..len.
- Active `pat`, `len` and `ovl`.

Reset:
- `hist`=0, `fill`=0.
- `pat`/`len`/`ovl` take their DEFAULT_* values.
- `seq_seen`=0, `cfg_err`=0, `match_cnt`=0.

Sampling cycle (`inp_valid`=1, `cfg_load`=0):
- `hist_n` = {hist[MAX_LEN-2:0], inp_bit}.
- `fill_n` = min(fill+1, len).
- match = (`fill_n` == len) and (`hist_n` & mask) == (`pat` & mask), where mask has its low `len` bits set.
- `seq_seen` <= match.
- On a match with `ovl`=1: `fill` <= `fill_n`, so trailing bits can start the next match.
- On a match with `ovl`=0: `fill` <= 0, so a further `len` fresh bits are required.

Idle cycle (`inp_valid`=0): `hist` and `fill` hold, `seq_seen` <= 0. Gaps between bits do not break a sequence.

Load cycle (`cfg_load`=1):
- If 1 <= `cfg_len` <= MAX_LEN: latch the new `pat`/`len`/`ovl`, clear `hist` and `fill`, set `seq_seen` <= 0, and clear `match_cnt` if present.
- Otherwise: `cfg_err` <= 1 and all other state is unchanged.
- `cfg_load` takes priority over `inp_valid`; a bit presented in the same cycle is discarded.
- Pattern bits above `cfg_len-1` are ignored.

Priority order: `reset` > `cfg_load` > `inp_valid`.

## Timing
- Moore-style output: `seq_seen` is high for exactly the one cycle after the edge that sampled the completing bit. Latency is 1 clock.
- Back-to-back matches: in overlap mode with `len`=1, `seq_seen` can stay high on consecutive cycles.
- `cfg_err` is a one-cycle pulse one clock after the illegal `cfg_load`.
- `match_cnt` increments in the same edge that sets `seq_seen`, so both are visible together. It saturates at 2^CNT_W-1.
- Reset asserted in the cycle of a completing bit: no match is reported, and `seq_seen`=0 on the next cycle.
- The new configuration takes effect on the first `inp_valid` cycle after the load edge.

## Configuration
- `SEQ_DETECT_MATCH_CNT_EN` defined: the `match_cnt` port and counter are built, with reset, clear and saturation exactly as above.
- Not defined: the port and counter logic are absent, and detection behaviour is identical.

## Test plan
- Reset defaults, bits 1,0,1,1 on consecutive valid cycles: `seq_seen`=1 for one cycle, one clock after the 4th bit, and `match_cnt`=1.
- Load `pattern`=3'b101, `len`=3, `overlap`=1, then stream 1,0,1,0,1: two pulses, after bits 3 and 5. Repeat with `overlap`=0: one pulse, after bit 3.
- Defaults, bits 1,0,1,1 with `inp_valid` low for 3 cycles between each bit: one pulse after the final 1, and `seq_seen`=0 throughout the idle cycles.
- Send 1,0,1, then `cfg_load` with the same pattern and `inp_valid`=1, `inp_bit`=1 in that cycle, then send 1: no pulse. Then load `cfg_len`=0: `cfg_err` pulses and 1,0,1,1 still matches.
- `CNT_W`=2 with the macro defined, six default-pattern matches: `match_cnt` reads 1,2,3,3,3,3.
- `reset` asserted in the cycle the final 1 of 1011 is presented: `seq_seen`=0 the next cycle, and a following 1 alone does not match.

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// Bundle of the serial input, configuration and result signals of seq_detect_prog.
// match_cnt and the CNT_W parameter exist only when SEQ_DETECT_MATCH_CNT_EN is defined.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8
`ifdef SEQ_DETECT_MATCH_CNT_EN
    , parameter int CNT_W = 8
`endif
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // inp_bit is consumed on every clock where inp_valid is high; the detector
    // has no backpressure, so there is no ready and a held valid means one bit per cycle.
    logic               inp_bit;
    logic               inp_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               seq_seen;
    logic               cfg_err;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    modport master (
        output inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  seq_seen, cfg_err
`ifdef SEQ_DETECT_MATCH_CNT_EN
        , input match_cnt
`endif
    );

    modport slave (
        input  inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output seq_seen, cfg_err
`ifdef SEQ_DETECT_MATCH_CNT_EN
        , output match_cnt
`endif
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: pulses seq_seen when the last len bits equal pat.
// Optional saturating match counter built when SEQ_DETECT_MATCH_CNT_EN is defined.
module seq_detect_prog #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(4'b1011),
    parameter int                 DEFAULT_LEN     = 4,
    parameter bit                 DEFAULT_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_prog_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
        $error("seq_detect_prog: MAX_LEN must be 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect_prog: CNT_W must be at least 1");
    end
    if (DEFAULT_LEN < 1 || DEFAULT_LEN > MAX_LEN) begin : g_bad_default_len
        $error("seq_detect_prog: DEFAULT_LEN must be 1..MAX_LEN");
    end

    // The oldest history bit is shifted out before it can ever be compared,
    // so only MAX_LEN-1 bits need to be stored.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               seen_r;
    logic               err_r;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic               cfg_ok;

    always_comb begin
        hist_n = {hist, bus.inp_bit};
        fill_n = (fill == len) ? fill : fill + 1'b1;
        mask   = ~({MAX_LEN{1'b1}} << len);
        match  = (fill_n == len) && ((hist_n & mask) == (pat & mask));
        cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    end

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;
    assign bus.match_cnt = cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hist   <= '0;
            fill   <= '0;
            pat    <= DEFAULT_PATTERN;
            len    <= LEN_W'(DEFAULT_LEN);
            ovl    <= DEFAULT_OVERLAP;
            seen_r <= 1'b0;
            err_r  <= 1'b0;
`ifdef SEQ_DETECT_MATCH_CNT_EN
            cnt    <= '0;
`endif
        end else begin
            seen_r <= 1'b0;
            err_r  <= 1'b0;
            if (bus.cfg_load) begin
                // A bit presented alongside a load is dropped in both branches.
                if (cfg_ok) begin
                    pat  <= bus.cfg_pattern;
                    len  <= bus.cfg_len;
                    ovl  <= bus.cfg_overlap;
                    hist <= '0;
                    fill <= '0;
`ifdef SEQ_DETECT_MATCH_CNT_EN
                    cnt  <= '0;
`endif
                end else begin
                    err_r <= 1'b1;
                end
            end else if (bus.inp_valid) begin
                hist   <= hist_n[MAX_LEN-2:0];
                fill   <= (match && !ovl) ? '0 : fill_n;
                seen_r <= match;
`ifdef SEQ_DETECT_MATCH_CNT_EN
                if (match && cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
`endif
            end
        end
    end

    assign bus.seq_seen = seen_r;
    assign bus.cfg_err  = err_r;
endmodule
